// File: rtl/alu_pipe.sv
// Registered ALU with a valid/ready handshake and an iterative shift-add multiplier.
// Single-cycle ops have latency 1; MUL occupies the block for WIDTH cycles.
module alu_pipe #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcod,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             Cout,
    output logic             V,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = {SHW{1'b1}};

    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               cout_q, cout_d;
    logic               v_q, v_d;
    logic               lt_q, lt_d;
    logic               eq_q, eq_d;
    logic               gt_q, gt_d;
    logic               zero_q, zero_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2:0]         cmp_q, cmp_d;

    logic               accept;
    logic               is_sub;
    logic               is_mul;
    logic [WIDTH-1:0]   y_eff;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   op_res;
    logic               op_cout;
    logic               op_v;
    logic               cmp_lt, cmp_eq, cmp_gt;
    logic [2*WIDTH-1:0] acc_step;

    assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign out       = out_q;
    assign Cout      = cout_q;
    assign V         = v_q;
    assign lt        = lt_q;
    assign eq        = eq_q;
    assign gt        = gt_q;
    assign zero      = zero_q;

    // Result of every single-cycle opcode; SUB reuses the adder with inverted Y and carry-in 1.
    always_comb begin
        op_res  = '0;
        op_cout = 1'b0;
        op_v    = 1'b0;
        is_sub  = (opcod == 3'b001);
        is_mul  = (opcod == 3'b111) && MUL_EN;
        y_eff   = is_sub ? ~Y : Y;
        sum     = {1'b0, X} + {1'b0, y_eff} + {{WIDTH{1'b0}}, is_sub};
        cmp_lt  = $signed(X) < $signed(Y);
        cmp_eq  = (X == Y);
        cmp_gt  = !cmp_lt && !cmp_eq;
        case (opcod)
            3'b000, 3'b001: begin
                op_res  = sum[WIDTH-1:0];
                op_cout = sum[WIDTH];
                op_v    = (X[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != X[WIDTH-1]);
            end
            3'b010:  op_res = X & Y;
            3'b011:  op_res = X | Y;
            3'b100:  op_res = {{(WIDTH-1){1'b0}}, cmp_lt};
            3'b110:  op_res = X << Y[SHW-1:0];
            default: op_res = '0;
        endcase
    end

    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        cout_d   = cout_q;
        v_d      = v_q;
        lt_d     = lt_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        zero_d   = zero_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        cmp_d    = cmp_q;

        case (state_q)
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // The last step writes the product straight into the result registers.
                if (cnt_q == CNT_LAST) begin
                    state_d            = HOLD;
                    out_d              = acc_step[WIDTH-1:0];
                    cout_d             = |acc_step[2*WIDTH-1:WIDTH];
                    v_d                = 1'b0;
                    zero_d             = (acc_step[WIDTH-1:0] == '0);
                    {lt_d, eq_d, gt_d} = cmp_q;
                end
            end
            HOLD: begin
                if (out_ready && !in_valid) state_d = IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            if (is_mul) begin
                state_d  = MUL;
                mcand_d  = {{WIDTH{1'b0}}, X};
                mplier_d = Y;
                acc_d    = '0;
                cnt_d    = '0;
                cmp_d    = {cmp_lt, cmp_eq, cmp_gt};
            end else begin
                state_d = HOLD;
                out_d   = op_res;
                cout_d  = op_cout;
                v_d     = op_v;
                lt_d    = cmp_lt;
                eq_d    = cmp_eq;
                gt_d    = cmp_gt;
                zero_d  = (op_res == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            out_q    <= '0;
            cout_q   <= 1'b0;
            v_q      <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            zero_q   <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            cmp_q    <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            cout_q   <= cout_d;
            v_q      <= v_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            zero_q   <= zero_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            cmp_q    <= cmp_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors push hand-computed results,
// independent monitors pop and compare on every output handshake.
module tb_alu_pipe;

    typedef struct {
        int          tag;
        logic [31:0] out;
        logic [5:0]  flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  opcod;
    logic [15:0] X, Y, out;
    logic        Cout, V, lt, eq, gt, zero;

    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [2:0]  opcod32;
    logic [31:0] X32, Y32, out32;
    logic        Cout32, V32, lt32, eq32, gt32, zero32;

    exp_t        q16[$];
    exp_t        q32[$];
    exp_t        e16, e32;
    int          vectors = 0;
    int          miscompares = 0;
    int          tag_next = 0;

    alu_pipe #(.WIDTH(16), .MUL_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcod(opcod), .X(X), .Y(Y), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .Cout(Cout), .V(V), .lt(lt), .eq(eq), .gt(gt), .zero(zero)
    );

    alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32),
        .opcod(opcod32), .X(X32), .Y(Y32), .out_valid(out_valid32), .out_ready(out_ready32),
        .out(out32), .Cout(Cout32), .V(V32), .lt(lt32), .eq(eq32), .gt(gt32), .zero(zero32)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Flags are packed as {Cout, V, lt, eq, gt, zero}.
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                                 input logic [15:0] exp_out, input logic [5:0] exp_flags,
                                 input bit push);
        exp_t e;
        bit   accepted;
        in_valid = 1'b1;
        opcod    = op;
        X        = x;
        Y        = y;
        if (push) begin
            e.tag   = tag_next;
            e.out   = {16'h0, exp_out};
            e.flags = exp_flags;
            q16.push_back(e);
        end
        tag_next++;
        accepted = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        X        = $urandom();
        Y        = $urandom();
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready && !out_valid) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) checkOutput("idle_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q16.size() == 0) begin
                checkOutput("unexpected_out16", 64'd1, 64'd0);
            end else begin
                e16 = q16.pop_front();
                checkOutput($sformatf("out16_v%0d", e16.tag), {32'h0, 16'h0, out}, {32'h0, e16.out});
                checkOutput($sformatf("flags16_v%0d", e16.tag), {58'h0, Cout, V, lt, eq, gt, zero},
                            {58'h0, e16.flags});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid32 && out_ready32) begin
            if (q32.size() == 0) begin
                checkOutput("unexpected_out32", 64'd1, 64'd0);
            end else begin
                e32 = q32.pop_front();
                checkOutput("out32", {32'h0, out32}, {32'h0, e32.out});
                checkOutput("flags32", {58'h0, Cout32, V32, lt32, eq32, gt32, zero32},
                            {58'h0, e32.flags});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  busy;
        bit  ready_seen;
        exp_t e;

        reset = 1'b1;
        in_valid = 1'b0; opcod = 3'b000; X = '0; Y = '0; out_ready = 1'b1;
        in_valid32 = 1'b0; opcod32 = 3'b000; X32 = '0; Y32 = '0; out_ready32 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", {46'h0, out_valid, out, Cout, V, lt, eq, gt, zero}, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", {63'h0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // flags: {Cout, V, lt, eq, gt, zero}
        applyStimulus(3'b000, 16'hFFFF, 16'h0001, 16'h0000, 6'b101001, 1'b1);
        applyStimulus(3'b001, 16'h8000, 16'h0001, 16'h7FFF, 6'b111000, 1'b1);
        applyStimulus(3'b001, 16'h0001, 16'h0002, 16'hFFFF, 6'b001000, 1'b1);
        applyStimulus(3'b100, 16'hFFFE, 16'h0003, 16'h0001, 6'b001000, 1'b1);
        applyStimulus(3'b101, 16'h1234, 16'h1234, 16'h0000, 6'b000101, 1'b1);
        applyStimulus(3'b101, 16'h0005, 16'h0003, 16'h0000, 6'b000011, 1'b1);
        applyStimulus(3'b110, 16'h0003, 16'h0004, 16'h0030, 6'b001000, 1'b1);
        applyStimulus(3'b011, 16'h00F0, 16'h0F00, 16'h0FF0, 6'b001000, 1'b1);

        applyStimulus(3'b111, 16'h0012, 16'h0034, 16'h03A8, 6'b001000, 1'b1);
        busy = 0;
        ready_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) break;
            busy++;
            if (in_ready) ready_seen = 1'b1;
        end
        checkOutput("mul_busy_cycles", 64'(busy), 64'd16);
        checkOutput("mul_in_ready_low", {63'h0, ready_seen}, 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(3'b111, 16'h0100, 16'h0100, 16'h0000, 6'b100101, 1'b1);
        waitIdle();

        out_ready = 1'b0;
        applyStimulus(3'b000, 16'h7FFF, 16'h0001, 16'h8000, 6'b010010, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_stable", {43'h0, out_valid, in_ready, out, V, Cout, gt},
                        {43'h0, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(3'b010, 16'h0F0F, 16'h00FF, 16'h000F, 6'b000010, 1'b1);
        @(negedge clk);
        checkOutput("no_bubble", {47'h0, out_valid, out}, {47'h0, 1'b1, 16'h000F});
        @(posedge clk);
        #1;

        applyStimulus(3'b111, 16'h0005, 16'h0007, 16'h0000, 6'b000000, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mul_abort", {46'h0, out_valid, in_ready, out}, {46'h0, 1'b0, 1'b1, 16'h0000});
        @(posedge clk);
        #1;
        applyStimulus(3'b000, 16'h0002, 16'h0003, 16'h0005, 6'b001000, 1'b1);

        in_valid32 = 1'b1;
        opcod32    = 3'b000;
        X32        = 32'hFFFF_FFFF;
        Y32        = 32'h0000_0001;
        e.tag      = tag_next;
        e.out      = 32'h0000_0000;
        e.flags    = 6'b101001;
        q32.push_back(e);
        ready_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready32) begin
                ready_seen = 1'b1;
                break;
            end
        end
        checkOutput("accept32", {63'h0, ready_seen}, 64'd1);
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;

        repeat (5) @(posedge clk);
        checkOutput("queue16_drained", 64'(q16.size()), 64'd0);
        checkOutput("queue32_drained", 64'(q32.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the 16-bit combinational ALU in the EX stage.
- Same opcode map for ops 000-101. Fixes 2's-complement subtraction (X + ~Y + 1). Adds SLL and an iterative shift-add multiply.
- Wrapped in a valid/ready handshake so the pipeline control can stall on the multicycle MUL.

Parameters:
- WIDTH, 16: operand/result width in bits, >=4, power of two.
- MUL_EN, 1: 1 = opcode 111 is an iterative multiply; 0 = opcode 111 returns 0 in a single cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block accepts when in_valid && in_ready.
- opcod  in  3  operation select.
- X  in  WIDTH  operand A.
- Y  in  WIDTH  operand B.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer takes the result when out_valid && out_ready.
- out  out  WIDTH  result.
- Cout  out  1  carry / no-borrow / MUL high-part nonzero.
- V  out  1  signed overflow (ADD/SUB only, else 0).
- lt, eq, gt  out  1 each  signed compare of X vs Y, valid for every op.
- zero  out  1  out == 0.

Behaviour:
- Reset: all outputs 0, state IDLE, in_ready 1 on the cycle after reset deasserts.
- Reset mid-MUL aborts the operation; no out_valid is produced.
- Opcodes:
  - 000 ADD: X+Y, cin 0.
  - 001 SUB: X+~Y+1; Cout = 1 when no borrow.
  - 010 AND.
  - 011 OR.
  - 100 SLT: out = {0..0, signed X<Y}.
  - 101 BNE: out = 0, flags only; eq = 0 signals "not equal".
  - 110 SLL: X << Y[log2(WIDTH)-1:0].
  - 111 MUL: low WIDTH bits of X*Y (unsigned); Cout = 1 if high WIDTH bits are nonzero.
- Flags:
  - V = sign(X')==sign(Y') && sign(out)!=sign(X'), where Y' = ~Y for SUB.
  - Cout = 0 for AND/OR/SLT/BNE/SLL.
  - lt/eq/gt are mutually exclusive, exactly one is 1 when out_valid.
- FSM states: IDLE, MUL, HOLD.
  - IDLE: on accept of a single-cycle op, the result and flags are registered; out_valid = 1 next cycle (latency 1); go to HOLD.
  - IDLE: on accept of MUL with MUL_EN=1, latch X, Y, zero a 2*WIDTH accumulator and an iteration counter; go to MUL.
  - MUL: one shift-add step per cycle for WIDTH cycles; the counter wraps at WIDTH-1. Then register the result and go to HOLD. out_valid rises WIDTH+1 cycles after the accept edge.
  - HOLD: out_valid = 1; out and flags are held stable while out_ready = 0.
  - HOLD: on out_ready = 1, out_valid drops next cycle unless a new op is accepted in the same cycle.
- in_ready = (state==IDLE) || (state==HOLD && out_ready).
  - This gives back-to-back single-cycle ops at full throughput.
  - in_ready is 0 throughout MUL.
- Simultaneous accept and drain in HOLD: the new result replaces the old one. Single-cycle op stays in HOLD; MUL goes to MUL and out_valid drops.
- Inputs are ignored when in_valid && !in_ready. Operands are sampled only at accept.
- Unused/invalid combinations: MUL_EN=0 with opcode 111 gives out = 0, Cout = 0, latency 1.

Test Plan:
- ADD X=0xFFFF Y=0x0001 -> one cycle later: out=0x0000, Cout=1, V=0, zero=1, eq=0, lt=1 (signed -1<1).
- SUB X=0x8000 Y=0x0001 -> out=0x7FFF, V=1, Cout=1; SUB X=0x0001 Y=0x0002 -> out=0xFFFF, Cout=0, V=0.
- SLT X=0xFFFE Y=0x0003 -> out=0x0001, lt=1; BNE X=Y=0x1234 -> out=0x0000, eq=1; SLL X=0x0003 Y=0x0004 -> out=0x0030.
- MUL X=0x0012 Y=0x0034 -> in_ready=0 for 16 cycles, out_valid at cycle 17, out=0x03A8, Cout=0; MUL 0x0100*0x0100 -> out=0x0000, Cout=1, zero=1.
- Back-pressure: ADD accepted, out_ready held 0 for 5 cycles -> out/flags stable, in_ready=0. Then out_ready=1 with a new AND 0x0F0F&0x00FF -> next cycle out=0x000F, no bubble.
- reset asserted 5 cycles into a MUL -> next cycle: out_valid=0, out=0, in_ready=1. A following ADD 2+3 -> out=0x0005. Repeat the ADD with WIDTH=32: 0xFFFFFFFF+1 -> Cout=1.
